// File: rtl/exec_slice_pkg.sv
// exec_slice_pkg
//   Shared definitions for the decode/execute/memory slice:
//   datapath and memory widths, instruction field positions,
//   the 4-bit opcode enum and a small opcode-extraction helper.
package exec_slice_pkg;

  localparam int DW = 8;   // datapath width
  localparam int AW = 8;   // data-memory address width, depth 2**AW
  localparam int IW = 9;   // instruction width

  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 5;
  localparam int RA_MSB   = 4;
  localparam int RA_LSB   = 3;
  localparam int IMM_MSB  = 2;
  localparam int IMM_LSB  = 0;
  localparam int TARG_MSB = 1;
  localparam int TARG_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SHL   = 4'h5,
    OP_SHR   = 4'h6,
    OP_ADDI  = 4'h7,
    OP_MOV   = 4'h8,
    OP_LDI   = 4'h9,
    OP_LOAD  = 4'hA,
    OP_STORE = 4'hB,
    OP_BRZ   = 4'hC,
    OP_CMP   = 4'hD,
    OP_NOP   = 4'hE,
    OP_HALT  = 4'hF
  } op_e;

  // All 16 codes are defined, so the cast can never produce an
  // out-of-range enum value.
  function automatic op_e decodeOp(input logic [IW-1:0] instr);
    return op_e'(instr[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/exec_slice_if.sv
// exec_slice_if
//   Bundles the instruction/operand inputs and the strobe, flag and
//   data outputs of exec_slice.
//   master : the surrounding core (register file / PC side) driving
//            the instruction and operands, observing the results.
//   slave  : exec_slice itself.
interface exec_slice_if;
  import exec_slice_pkg::*;

  logic [IW-1:0] Instruction;
  logic [DW-1:0] DataA;
  logic [DW-1:0] DataB;
  logic          SC_in;

  logic          BranchEn;
  logic          RegWrEn;
  logic          MemWrEn;
  logic          ALUEn;
  logic          Ack;
  logic [1:0]    TargSel;
  logic [DW-1:0] AluOut;
  logic          Zero;
  logic          Parity;
  logic          Odd;
  logic [DW-1:0] MemOut;
  logic [DW-1:0] WbData;

  modport master (
    output Instruction, DataA, DataB, SC_in,
    input  BranchEn, RegWrEn, MemWrEn, ALUEn, Ack, TargSel,
    input  AluOut, Zero, Parity, Odd, MemOut, WbData
  );

  modport slave (
    input  Instruction, DataA, DataB, SC_in,
    output BranchEn, RegWrEn, MemWrEn, ALUEn, Ack, TargSel,
    output AluOut, Zero, Parity, Odd, MemOut, WbData
  );

endinterface

// File: rtl/exec_alu.sv
// exec_alu
//   Purely combinational ALU for the slice.
//   Ports:
//     op     in   opcode
//     A, B   in   register-file operands
//     imm    in   3-bit immediate, zero-extended where used
//     SC_in  in   shift carry-in
//     AluOut out  result, modulo 2**DW
//     Zero, Parity, Odd  out  flags derived from AluOut
module exec_alu
  import exec_slice_pkg::*;
(
  input  op_e           op,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [2:0]    imm,
  input  logic          SC_in,
  output logic [DW-1:0] AluOut,
  output logic          Zero,
  output logic          Parity,
  output logic          Odd
);

  always_comb begin
    AluOut = '0;
    unique case (op)
      OP_ADD:   AluOut = A + B;
      OP_SUB:   AluOut = A - B;
      OP_AND:   AluOut = A & B;
      OP_OR:    AluOut = A | B;
      OP_XOR:   AluOut = A ^ B;
      OP_SHL:   AluOut = {A[DW-2:0], SC_in};
      OP_SHR:   AluOut = {SC_in, A[DW-1:1]};
      OP_ADDI:  AluOut = A + DW'(imm);
      OP_MOV:   AluOut = B;
      OP_LDI:   AluOut = DW'(imm);
      OP_LOAD:  AluOut = B;   // passes the address through; write-back comes from memory
      OP_STORE: AluOut = A;
      OP_BRZ:   AluOut = A;   // Zero then reflects A for the PC's branch decision
      OP_CMP:   AluOut = A - B;
      OP_NOP:   AluOut = '0;
      OP_HALT:  AluOut = '0;
      default:  AluOut = '0;
    endcase
  end

  assign Zero   = (AluOut == '0);
  assign Parity = ^AluOut;
  assign Odd    = AluOut[0];

endmodule

// File: rtl/exec_slice.sv
// exec_slice
//   Single-cycle decode/execute/memory slice of the 9-bit-instruction,
//   8-bit-datapath processor. Decodes the instruction into PC and
//   register-file strobes, runs the ALU, holds the data memory and
//   selects the write-back value.
//   Ports:
//     Clk    in   clock, posedge
//     Reset  in   synchronous, active-high; clears the data memory
//     bus    slave side of exec_slice_if (instruction, operands,
//            strobes, flags, MemOut, WbData)
module exec_slice
  import exec_slice_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  exec_slice_if.slave bus
);

  op_e           op;
  logic [2:0]    imm;
  logic [DW-1:0] aluOut;
  logic [DW-1:0] memOut;
  logic [DW-1:0] mem [2**AW];

  // ra selects the write-back register inside the register file; the
  // slice itself never needs it.
  logic          unusedRa;
  assign unusedRa = ^bus.Instruction[RA_MSB:RA_LSB];

  assign op  = decodeOp(bus.Instruction);
  assign imm = bus.Instruction[IMM_MSB:IMM_LSB];

  exec_alu uAlu (
    .op     (op),
    .A      (bus.DataA),
    .B      (bus.DataB),
    .imm    (imm),
    .SC_in  (bus.SC_in),
    .AluOut (aluOut),
    .Zero   (bus.Zero),
    .Parity (bus.Parity),
    .Odd    (bus.Odd)
  );

  // Decode: strobes are combinational and independent of Reset.
  always_comb begin
    bus.BranchEn = 1'b0;
    bus.RegWrEn  = 1'b0;
    bus.MemWrEn  = 1'b0;
    bus.ALUEn    = 1'b0;
    bus.Ack      = 1'b0;
    bus.TargSel  = 2'd0;
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_ADDI, OP_MOV, OP_LDI: begin
        bus.RegWrEn = 1'b1;
        bus.ALUEn   = 1'b1;
      end
      OP_LOAD:  bus.RegWrEn = 1'b1;
      OP_STORE: bus.MemWrEn = 1'b1;
      OP_BRZ: begin
        bus.BranchEn = 1'b1;
        bus.TargSel  = bus.Instruction[TARG_MSB:TARG_LSB];
      end
      OP_HALT:  bus.Ack = 1'b1;
      OP_CMP, OP_NOP: ;
      default: ;
    endcase
  end

  // Data memory: asynchronous read, synchronous write; Reset wins
  // over a simultaneous STORE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (bus.MemWrEn) begin
      mem[bus.DataB[AW-1:0]] <= bus.DataA;
    end
  end

  assign memOut     = mem[bus.DataB[AW-1:0]];
  assign bus.AluOut = aluOut;
  assign bus.MemOut = memOut;
  assign bus.WbData = bus.ALUEn ? aluOut : memOut;

endmodule

// File: tb/tb_exec_slice.sv
// tb_exec_slice
//   Directed test-plan steps followed by randomized instructions, each
//   compared against a behavioural model of the slice and its memory.
module tb_exec_slice;

  logic Clk;
  logic Reset;
  int   vectors;
  int   miscompares;

  exec_slice_if bus ();

  exec_slice dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference memory image
  logic [7:0] mdl [256];

  // Expected outputs of the last step
  int expAlu, expZ, expP, expO, expStrobes, expTarg, expMem, expWb;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model written from the opcode rules using plain integer arithmetic.
  task automatic model(input logic [8:0] ins, input int a, input int b, input int sc);
    logic [8:0] insv;
    int op, imm, alu, ones, regwr, memwr, aluen, br, ack;
    insv = ins;
    op   = int'(insv[8:5]);
    imm  = int'(insv[2:0]);
    case (op)
      0:  alu = a + b;
      1:  alu = a - b + 256;
      2:  alu = a & b;
      3:  alu = a | b;
      4:  alu = a ^ b;
      5:  alu = a * 2 + sc;
      6:  alu = a / 2 + sc * 128;
      7:  alu = a + imm;
      8:  alu = b;
      9:  alu = imm;
      10: alu = b;
      11: alu = a;
      12: alu = a;
      13: alu = a - b + 256;
      default: alu = 0;
    endcase
    alu = alu % 256;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += (alu >> k) % 2;
    regwr = (op <= 10) ? 1 : 0;
    aluen = (op <= 9) ? 1 : 0;
    memwr = (op == 11) ? 1 : 0;
    br    = (op == 12) ? 1 : 0;
    ack   = (op == 15) ? 1 : 0;
    expAlu     = alu;
    expZ       = (alu == 0) ? 1 : 0;
    expP       = ones % 2;
    expO       = alu % 2;
    expStrobes = br * 16 + regwr * 8 + memwr * 4 + aluen * 2 + ack;
    expTarg    = br ? int'(insv[1:0]) : 0;
    expMem     = int'(mdl[b]);
    expWb      = aluen ? alu : expMem;
  endtask

  // Present one instruction for a full cycle, check outputs before the
  // commit edge, then advance the memory model past that edge.
  task automatic step(input logic [8:0] ins, input logic [7:0] a, input logic [7:0] b,
                      input logic sc, input logic rst);
    @(negedge Clk);
    bus.Instruction = ins;
    bus.DataA       = a;
    bus.DataB       = b;
    bus.SC_in       = sc;
    Reset           = rst;
    #1;
    model(ins, int'(a), int'(b), int'(sc));
    check("alu",     16'(bus.AluOut), 16'(expAlu));
    check("flags",   16'({bus.Zero, bus.Parity, bus.Odd}), 16'(expZ * 4 + expP * 2 + expO));
    check("strobes", 16'({bus.BranchEn, bus.RegWrEn, bus.MemWrEn, bus.ALUEn, bus.Ack}), 16'(expStrobes));
    check("targsel", 16'(bus.TargSel), 16'(expTarg));
    check("memout",  16'(bus.MemOut), 16'(expMem));
    check("wbdata",  16'(bus.WbData), 16'(expWb));
    if (rst) begin
      for (int k = 0; k < 256; k++) mdl[k] = 8'h00;
    end else if (ins[8:5] == 4'hB) begin
      mdl[b] = a;
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [4:0] low);
    return {op, low};
  endfunction

  initial begin
    logic [8:0] ins;
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 256; k++) mdl[k] = 8'h00;
    Reset           = 1'b1;
    bus.Instruction = 9'h1FF;
    bus.DataA       = 8'h00;
    bus.DataB       = 8'h00;
    bus.SC_in       = 1'b0;
    repeat (2) @(posedge Clk);

    // Reset state: memory reads zero after reset
    step(mk(4'hA, 5'd0), 8'h00, 8'h00, 1'b0, 1'b0);
    check("reset_mem_ff", 16'(bus.MemOut), 16'h0000);
    step(mk(4'hA, 5'd0), 8'h00, 8'hFF, 1'b0, 1'b0);

    // ADD
    step(mk(4'h0, 5'd0), 8'hF0, 8'h20, 1'b0, 1'b0);
    check("plan_add_alu", 16'(bus.AluOut), 16'h0010);
    check("plan_add_par", 16'(bus.Parity), 16'h0001);
    check("plan_add_wb",  16'(bus.WbData), 16'h0010);
    // SUB / CMP to zero
    step(mk(4'h1, 5'd0), 8'h5A, 8'h5A, 1'b0, 1'b0);
    check("plan_sub_zero", 16'(bus.Zero), 16'h0001);
    step(mk(4'hD, 5'd0), 8'h5A, 8'h5A, 1'b0, 1'b0);
    check("plan_cmp_wr", 16'({bus.RegWrEn, bus.MemWrEn}), 16'h0000);
    // Shifts and ADDI wraparound
    step(mk(4'h5, 5'd0), 8'h81, 8'h00, 1'b1, 1'b0);
    check("plan_shl", 16'(bus.AluOut), 16'h0003);
    step(mk(4'h6, 5'd0), 8'h81, 8'h00, 1'b1, 1'b0);
    check("plan_shr", 16'(bus.AluOut), 16'h00C0);
    step(mk(4'h7, 5'd3), 8'hFE, 8'h00, 1'b0, 1'b0);
    check("plan_addi", 16'(bus.AluOut), 16'h0001);
    // STORE then LOAD, plus unwritten address
    step(mk(4'hB, 5'd0), 8'h3C, 8'h07, 1'b0, 1'b0);
    step(mk(4'hA, 5'd0), 8'h00, 8'h07, 1'b0, 1'b0);
    check("plan_load_wb", 16'(bus.WbData), 16'h003C);
    step(mk(4'hA, 5'd0), 8'h00, 8'h08, 1'b0, 1'b0);
    check("plan_unwritten", 16'(bus.MemOut), 16'h0000);
    // Reset over STORE, then earlier-written location reads 0
    step(mk(4'hB, 5'd0), 8'h55, 8'h09, 1'b0, 1'b1);
    step(mk(4'hA, 5'd0), 8'h00, 8'h09, 1'b0, 1'b0);
    check("plan_rst_store", 16'(bus.MemOut), 16'h0000);
    step(mk(4'hA, 5'd0), 8'h00, 8'h07, 1'b0, 1'b0);
    check("plan_rst_clear", 16'(bus.MemOut), 16'h0000);
    // BRZ and HALT/idle
    step(mk(4'hC, 5'd2), 8'h00, 8'h00, 1'b0, 1'b0);
    check("plan_brz", 16'({bus.BranchEn, bus.Zero, bus.TargSel}), 16'h000E);
    step(mk(4'hC, 5'd2), 8'h01, 8'h00, 1'b0, 1'b0);
    step(9'h1FF, 8'h12, 8'h34, 1'b1, 1'b0);
    check("plan_idle", 16'({bus.Ack, bus.RegWrEn, bus.MemWrEn}), 16'h0004);

    // Random traffic on a small address window so loads hit stores
    for (int n = 0; n < 400; n++) begin
      ins = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) ins[8:5] = 4'hB;
      else if ($urandom_range(0, 3) == 0) ins[8:5] = 4'hA;
      step(ins, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
